// File: rtl/axi4_lite_arbiter.sv
// Two-requester arbiter in front of a single master command port (IDLE/ISSUE/WAIT/DONE).
// Define ARB_FIXED_PRIO_EN for fixed priority (requester 0 first); default is round-robin.
module axi4_lite_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              m0_valid,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m1_valid,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m0_ack,
  output logic              m0_done,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m1_ack,
  output logic              m1_done,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] addr,
  output logic              write,
  output logic [DATA_W-1:0] wdata,
  output logic              transfer,
  input  logic              ready,
  input  logic [DATA_W-1:0] rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                write_q, write_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                transfer_q, transfer_d;
  logic [1:0]          ack_q, ack_d;
  logic [1:0]          done_q, done_d;
  logic                win_q, win_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d;
  logic [DATA_W-1:0]   rdata1_q, rdata1_d;
  logic                any_valid;
  logic                grant_idx;
`ifndef ARB_FIXED_PRIO_EN
  logic                last_q, last_d;
`endif

  assign any_valid = m0_valid | m1_valid;

  // Winner among the currently valid requesters; only consulted in IDLE.
  always_comb begin
`ifdef ARB_FIXED_PRIO_EN
    grant_idx = ~m0_valid;
`else
    if (m0_valid && m1_valid) grant_idx = ~last_q;
    else                      grant_idx = ~m0_valid;
`endif
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d    = state_q;
    addr_d     = addr_q;
    write_d    = write_q;
    wdata_d    = wdata_q;
    win_d      = win_q;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    transfer_d = 1'b0;
    ack_d      = 2'b00;
    done_d     = 2'b00;
`ifndef ARB_FIXED_PRIO_EN
    last_d     = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          state_d    = ISSUE;
          win_d      = grant_idx;
          addr_d     = grant_idx ? m1_addr  : m0_addr;
          write_d    = grant_idx ? m1_write : m0_write;
          wdata_d    = grant_idx ? m1_wdata : m0_wdata;
          transfer_d = 1'b1;
          ack_d      = grant_idx ? 2'b10 : 2'b01;
`ifndef ARB_FIXED_PRIO_EN
          last_d     = grant_idx;
`endif
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (ready) begin
          state_d = DONE;
          done_d  = win_q ? 2'b10 : 2'b01;
          // Writes report zero so a stale read value never leaks into a write completion.
          if (win_q) rdata1_d = write_q ? '0 : rdata;
          else       rdata0_d = write_q ? '0 : rdata;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      transfer_q <= 1'b0;
      ack_q      <= 2'b00;
      done_q     <= 2'b00;
      win_q      <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
`ifndef ARB_FIXED_PRIO_EN
      last_q     <= 1'b1;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q    <= state_d;
      addr_q     <= addr_d;
      write_q    <= write_d;
      wdata_q    <= wdata_d;
      transfer_q <= transfer_d;
      ack_q      <= ack_d;
      done_q     <= done_d;
      win_q      <= win_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
`ifndef ARB_FIXED_PRIO_EN
      last_q     <= last_d;
`endif
    end
  end

  assign addr     = addr_q;
  assign write    = write_q;
  assign wdata    = wdata_q;
  assign transfer = transfer_q;
  assign m0_ack   = ack_q[0];
  assign m1_ack   = ack_q[1];
  assign m0_done  = done_q[0];
  assign m1_done  = done_q[1];
  assign m0_rdata = rdata0_q;
  assign m1_rdata = rdata1_q;

endmodule

// File: doc/axi4_lite_arbiter.md
AXI4_LITE_ARBITER -- requirements
Module: axi4_lite_arbiter

Interface
REQ-001 Parameter: ADDR_W, 4, width of the request address and of the downstream addr.
REQ-002 Parameter: DATA_W, 32, width of write and read data.
REQ-003 Port: ACLK  in  1  single system clock; all state updates on its rising edge.
REQ-004 Port: ARESET  in  1  asynchronous, active-high reset.
REQ-005 Ports, one set per requester, n = 0 and 1:
  - m<n>_valid  in  1  request pending.
  - m<n>_addr  in  ADDR_W  request address.
  - m<n>_write  in  1  1 = write, 0 = read.
  - m<n>_wdata  in  DATA_W  write data.
REQ-006 Ports, one set per requester, n = 0 and 1:
  - m<n>_ack  out  1  request accepted; one-cycle pulse.
  - m<n>_done  out  1  transaction complete; one-cycle pulse.
  - m<n>_rdata  out  DATA_W  read result.
REQ-007 Ports toward the master command interface:
  - addr  out  ADDR_W.
  - write  out  1.
  - wdata  out  DATA_W.
  - transfer  out  1  one-cycle start pulse.
  - ready  in  1  completion pulse.
  - rdata  in  DATA_W  read data, valid when ready=1.

Function
REQ-008 The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT, DONE.
REQ-009 IDLE SHALL behave as follows.
  - If any m<n>_valid=1 at a rising edge: select a winner, capture its addr/write/wdata into registers, record the winner index, go to ISSUE.
  - Otherwise stay in IDLE.
REQ-010 ISSUE SHALL last exactly one cycle.
  - transfer=1 and the winner's m<n>_ack=1.
  - addr/write/wdata driven from the captured registers.
  - Then go to WAIT.
REQ-011 WAIT SHALL hold transfer=0 and the captured addr/write/wdata stable, and go to DONE on the first edge where ready=1; ready SHALL be ignored in every other state.
REQ-012 On the WAIT-to-DONE edge the arbiter SHALL capture rdata for reads and 0 for writes into the winner's m<n>_rdata; m<n>_rdata SHALL then hold that value until the next completion for the same requester.
REQ-013 DONE SHALL last exactly one cycle, assert the winner's m<n>_done=1, then go to IDLE.
REQ-014 Minimum latency SHALL be as follows.
  - Valid sampled at edge N: ack and transfer are high during cycle N+1.
  - Ready sampled high at edge K: done is high during cycle K+1.
  - Back-to-back grants are possible every 4 cycles when ready returns 1 cycle after transfer.
REQ-015 Requesters SHALL hold valid and payload stable until they see ack; valid seen during ISSUE, WAIT or DONE SHALL NOT alter the captured transaction.
REQ-016 Default arbitration SHALL be round-robin.
  - A last_grant register is updated on every grant.
  - When both requesters are valid in IDLE, the requester not equal to last_grant wins.
  - When only one is valid, it wins regardless of last_grant.
REQ-017 At most one ack, one done and one transfer SHALL be high in any cycle.
REQ-018 A requester still valid after DONE SHALL be eligible in the immediately following IDLE cycle.

Reset
REQ-019 While ARESET=1 the arbiter SHALL asynchronously force the following.
  - State IDLE.
  - transfer=0, all m<n>_ack=0 and m<n>_done=0.
  - addr=0, write=0, wdata=0, all m<n>_rdata=0.
  - last_grant=1, so requester 0 wins the first tie.
REQ-020 Reset asserted during ISSUE, WAIT or DONE SHALL abandon the transaction with no done pulse; a ready arriving after reset release SHALL be ignored unless the FSM is in WAIT.

Configuration
REQ-021 With macro ARB_FIXED_PRIO_EN defined, arbitration SHALL be fixed priority: requester 0 always wins when both are valid, and last_grant is unused.
REQ-022 Without ARB_FIXED_PRIO_EN, arbitration SHALL be round-robin per REQ-016; all other behaviour SHALL be identical in both builds.

Verification
REQ-023 Single write, no contention:
  - Stimulus: m0 write addr=4'h4, wdata=32'h2; ready pulsed 2 cycles after transfer.
  - Expected: m0_ack and transfer together; addr=4'h4 and wdata=2 stable until done; m0_done once; m0_rdata=0.
REQ-024 Read:
  - Stimulus: m1 read addr=4'hC; ready pulsed with rdata=32'h4.
  - Expected: m1_done 1 cycle after ready; m1_rdata=32'h4; m0 outputs unchanged.
REQ-025 Contention, round-robin build:
  - Stimulus: m0 and m1 valid in the same cycle immediately after reset, both held until ack.
  - Expected: grant order m0 then m1; then with both reasserted, m0 again, so grants alternate.
REQ-026 Contention, ARB_FIXED_PRIO_EN build:
  - Stimulus: m0 and m1 continuously valid for 3 transactions each.
  - Expected: all three m0 transactions complete before any m1 ack.
REQ-027 Reset mid-transaction:
  - Stimulus: assert ARESET during WAIT.
  - Expected: transfer, acks and dones are 0 immediately; no done pulse; a later ready pulse produces no done; the next request is granted normally.
REQ-028 Ready outside WAIT:
  - Stimulus: ready=1 while in IDLE and during ISSUE.
  - Expected: no state change and no done pulse.
